// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level MIPS requests into words and streams them to IM.
// Build option INSTR_ENCODER_NOP_PAD_EN appends a delay-slot nop after branches/jumps.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_valid,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [31:0]       im_pc,
  output logic [ADDR_W:0]   word_cnt,
  output logic              full,
  output logic              err
);

`ifdef INSTR_ENCODER_NOP_PAD_EN
  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_SLOT, S_FULL
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_FULL
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              last;

`ifdef INSTR_ENCODER_NOP_PAD_EN
  logic enc_branch;
  logic pend_br;
`endif

  assign full     = word_cnt[ADDR_W];
  assign last     = (word_cnt == CNT_LAST);
  assign in_ready = (state == S_IDLE) && !full && !clear;
  assign im_pc    = BASE_ADDR + 32'({im_addr, 2'b00});

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    unique case (1'b1)
      (in_kind == 4'd0): enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h21};
      (in_kind == 4'd1): enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h23};
      (in_kind == 4'd2): enc_word = {6'h0D, in_rs, in_rt, in_imm};
      (in_kind == 4'd3): enc_word = {6'h0F, 5'h00, in_rt, in_imm};
      (in_kind == 4'd4): enc_word = {6'h23, in_rs, in_rt, in_imm};
      (in_kind == 4'd5): enc_word = {6'h2B, in_rs, in_rt, in_imm};
      (in_kind == 4'd6): enc_word = {6'h04, in_rs, in_rt, in_imm};
      (in_kind == 4'd7): enc_word = {6'h02, in_target};
      (in_kind == 4'd8): enc_word = {6'h03, in_target};
      (in_kind == 4'd9): enc_word = {6'h00, in_rs, 15'h0, 6'h08};
      default:           enc_legal = 1'b0;
    endcase
  end

`ifdef INSTR_ENCODER_NOP_PAD_EN
  assign enc_branch = (in_kind >= 4'd6) && (in_kind <= 4'd9);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
      im_valid <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
      pend_br  <= 1'b0;
`endif
    end else if (clear) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
      im_valid <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
      pend_br  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (enc_legal) begin
              im_wdata <= enc_word;
              im_addr  <= wr_ptr;
              im_valid <= 1'b1;
              state    <= S_SEND;
`ifdef INSTR_ENCODER_NOP_PAD_EN
              pend_br  <= enc_branch;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (im_ready) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            word_cnt <= word_cnt + CNT_ONE;
            im_valid <= 1'b0;
            state    <= last ? S_FULL : S_IDLE;
`ifdef INSTR_ENCODER_NOP_PAD_EN
            // No room left for the delay slot: drop it and flag
            if (pend_br) begin
              pend_br <= 1'b0;
              if (last) begin
                err <= 1'b1;
              end else begin
                im_valid <= 1'b1;
                im_addr  <= wr_ptr + PTR_ONE;
                im_wdata <= 32'h0;
                state    <= S_SLOT;
              end
            end
`endif
          end
        end
`ifdef INSTR_ENCODER_NOP_PAD_EN
        S_SLOT: begin
          if (im_ready) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            word_cnt <= word_cnt + CNT_ONE;
            im_valid <= 1'b0;
            state    <= last ? S_FULL : S_IDLE;
          end
        end
`endif
        S_FULL: begin
          im_valid <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random checks of instr_encoder (ADDR_W=2)
// against a field-arithmetic reference model and a write scoreboard.
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

module tb_instr_encoder;
  localparam int AW = 2;
  localparam int CAP = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_3000;
`ifdef INSTR_ENCODER_NOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] w;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_kind = '0;
  logic [4:0]    in_rs = '0;
  logic [4:0]    in_rt = '0;
  logic [4:0]    in_rd = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          im_valid;
  logic          im_ready = 1'b0;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [31:0]   im_pc;
  logic [AW:0]   word_cnt;
  logic          full;
  logic          err;

  int  total = 0;
  int  bad = 0;
  bit  rnd_rdy = 1'b0;
  int  m_cnt = 0;
  bit  m_err = 1'b0;
  wr_t obs_q[$];
  wr_t exp_q[$];

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .im_valid(im_valid), .im_ready(im_ready),
    .im_addr(im_addr), .im_wdata(im_wdata), .im_pc(im_pc),
    .word_cnt(word_cnt), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset && !clear && im_valid && im_ready)
      obs_q.push_back(wr_t'{32'(im_addr), im_pc, im_wdata});

  function automatic logic [31:0] ref_enc(
    input logic [3:0] k, input logic [4:0] rs, rt, rd,
    input logic [15:0] imm, input logic [25:0] tgt,
    output bit lg, output bit br);
    int unsigned s, t, d, i, g;
    s = 32'(rs) << 21;
    t = 32'(rt) << 16;
    d = 32'(rd) << 11;
    i = 32'(imm);
    g = 32'(tgt);
    lg = 1'b1;
    br = (k >= 4'd6) && (k <= 4'd9);
    case (k)
      4'd0: return s + t + d + 32'd33;
      4'd1: return s + t + d + 32'd35;
      4'd2: return (32'd13 << 26) + s + t + i;
      4'd3: return (32'd15 << 26) + t + i;
      4'd4: return (32'd35 << 26) + s + t + i;
      4'd5: return (32'd43 << 26) + s + t + i;
      4'd6: return (32'd4 << 26) + s + t + i;
      4'd7: return (32'd2 << 26) + g;
      4'd8: return (32'd3 << 26) + g;
      4'd9: return s + 32'd8;
      default: begin
        lg = 1'b0;
        return 32'd0;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) im_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic expect_write(input logic [31:0] w);
    exp_q.push_back(wr_t'{32'(m_cnt), BASE + 32'(4 * m_cnt), w});
    m_cnt++;
  endtask

  task automatic set_fields(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                            input logic [15:0] imm, input logic [25:0] tgt);
    in_kind = k;
    in_rs = rs;
    in_rt = rt;
    in_rd = rd;
    in_imm = imm;
    in_target = tgt;
  endtask

  task automatic req(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                     input logic [15:0] imm, input logic [25:0] tgt);
    bit lg, br;
    logic [31:0] w;
    int n;
    set_fields(k, rs, rt, rd, imm, tgt);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $error("FAIL req_wait_ready expired after %0d cycles", n);
    end
    `CHK("req_ready", in_ready, 1'b1)
    tick();
    in_valid = 1'b0;
    w = ref_enc(k, rs, rt, rd, imm, tgt, lg, br);
    if (!lg) begin
      m_err = 1'b1;
    end else begin
      expect_write(w);
      if (br && PAD) begin
        if (m_cnt < CAP) expect_write(32'h0);
        else m_err = 1'b1;
      end
    end
    n = 0;
    while (im_valid && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $error("FAIL req_wait_drain expired after %0d cycles", n);
    end
  endtask

  task automatic finish_step();
    wr_t o;
    wr_t e;
    `CHK("st_valid", im_valid, 1'b0)
    `CHK("st_cnt", word_cnt, (AW+1)'(m_cnt))
    `CHK("st_err", err, m_err)
    `CHK("st_full", full, (m_cnt == CAP))
    `CHK("st_ready", in_ready, (m_cnt != CAP))
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      `CHK("write", o, e)
    end
    `CHK("extra_writes", obs_q.size(), 0)
    obs_q.delete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    m_cnt = 0;
    m_err = 1'b0;
    exp_q.delete();
    `CHK("clr_cnt", word_cnt, (AW+1)'(0))
    `CHK("clr_err", err, 1'b0)
    `CHK("clr_valid", im_valid, 1'b0)
    `CHK("clr_addr", im_addr, AW'(0))
    `CHK("clr_full", full, 1'b0)
    `CHK("clr_ready", in_ready, 1'b1)
  endtask

  initial begin
    logic [3:0] k;
    repeat (2) @(posedge clk);
    #1;
    `CHK("rst_valid", im_valid, 1'b0)
    `CHK("rst_addr", im_addr, AW'(0))
    `CHK("rst_data", im_wdata, 32'h0)
    `CHK("rst_cnt", word_cnt, (AW+1)'(0))
    `CHK("rst_full", full, 1'b0)
    `CHK("rst_err", err, 1'b0)
    total++;
    if (im_valid !== 1'b0 || word_cnt !== '0 || full !== 1'b0 || err !== 1'b0) begin
      bad++;
      $error("FAIL reset_state valid=%0b cnt=%0d full=%0b err=%0b",
             im_valid, word_cnt, full, err);
    end
    reset = 1'b1;
    tick();
    `CHK("idle_ready", in_ready, 1'b1)

    im_ready = 1'b1;
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    `CHK("lat_valid", im_valid, 1'b1)
    `CHK("lat_addr", im_addr, AW'(0))
    `CHK("lat_data", im_wdata, 32'h0022_1821)
    `CHK("lat_pc", im_pc, 32'h0000_3000)
    `CHK("lat_busy", in_ready, 1'b0)
    `CHK("lat_cnt", word_cnt, (AW+1)'(0))
    tick();
    expect_write(32'h0022_1821);
    finish_step();

    do_clear();
    req(4'd2, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0);
    req(4'd3, 5'd7, 5'd1, 5'd0, 16'hABCD, 26'h0);
    `CHK("ori_word", obs_q[0].w, 32'h3408_1234)
    `CHK("lui_word", obs_q[1].w, 32'h3C01_ABCD)
    `CHK("lui_pc", obs_q[1].pc, 32'h0000_3004)
    finish_step();

    do_clear();
    im_ready = 1'b0;
    set_fields(4'd5, 5'd29, 5'd4, 5'd0, 16'h0010, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) begin
      tick();
      `CHK("stall_valid", im_valid, 1'b1)
      `CHK("stall_addr", im_addr, AW'(0))
      `CHK("stall_data", im_wdata, 32'hAFA4_0010)
      `CHK("stall_ready", in_ready, 1'b0)
      `CHK("stall_cnt", word_cnt, (AW+1)'(0))
    end
    im_ready = 1'b1;
    tick();
    expect_write(32'hAFA4_0010);
    finish_step();
    im_ready = 1'b0;
    set_fields(4'd4, 5'd3, 5'd5, 5'd0, 16'h0004, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    im_ready = 1'b1;
    do_clear();
    `CHK("drop_writes", obs_q.size(), 0)

    req(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C03);
    req(4'd9, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0);
    `CHK("jal_word", obs_q[0].w, 32'h0C00_0C03)
`ifdef INSTR_ENCODER_NOP_PAD_EN
    `CHK("jal_nop", obs_q[1].w, 32'h0)
    `CHK("jr_word", obs_q[2].w, 32'h03E0_0008)
    `CHK("jr_nop", obs_q[3].w, 32'h0)
    `CHK("pad_cnt", word_cnt, (AW+1)'(4))
`else
    `CHK("jr_word", obs_q[1].w, 32'h03E0_0008)
    `CHK("jr_cnt", word_cnt, (AW+1)'(2))
`endif
    finish_step();

    do_clear();
    req(4'd1, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0);
    finish_step();
    req(4'hF, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF);
    `CHK("ill_err", err, 1'b1)
    finish_step();
    do_clear();

    repeat (CAP) req(4'd0, 5'($urandom), 5'($urandom), 5'($urandom), 16'h0, 26'h0);
    finish_step();
    `CHK("full_addr", im_addr, AW'(CAP - 1))
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    `CHK("full_hold_cnt", word_cnt, (AW+1)'(CAP))
    `CHK("full_hold_valid", im_valid, 1'b0)
    `CHK("full_no_writes", obs_q.size(), 0)
    do_clear();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (m_cnt == CAP) begin
        `CHK("rnd_full", full, 1'b1)
        `CHK("rnd_full_ready", in_ready, 1'b0)
        do_clear();
      end else if ($urandom_range(0, 11) == 0) begin
        do_clear();
      end else begin
        k = 4'($urandom_range(0, 11));
        req(k, 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 26'($urandom));
        finish_step();
      end
    end
    rnd_rdy = 1'b0;
    im_ready = 1'b0;
    do_clear();

    set_fields(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    `CHK("mid_valid", im_valid, 1'b1)
    #2 reset = 1'b0;
    #1;
    `CHK("async_valid", im_valid, 1'b0)
    `CHK("async_cnt", word_cnt, (AW+1)'(0))
    #1 reset = 1'b1;
    im_ready = 1'b1;
    tick();
    `CHK("post_rst_ready", in_ready, 1'b1)
    `CHK("post_rst_writes", obs_q.size(), 0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
